// File: rtl/ultrasonic_ping_scheduler.sv
// ultrasonic_ping_scheduler
// Time-shares up to NUM_SENSORS ultrasonic rangers so only one sensor pings at
// a time. Enabled sensors are visited round-robin. Each ping raises the trigger,
// times the echo pulse and posts one distance result (in cm) or a timeout.
//
// Ports
//   clk          system clock
//   reset_l      asynchronous reset, active low
//   enable       1 = keep scheduling; 0 = stop once the current ping is done
//   sensor_mask  bit i includes sensor i in the rotation (sampled in SELECT)
//   echo         raw echo pins, asynchronous to clk
//   trigger      trigger pins, at most one high at a time
//   dist_data    distance in cm, 16'hFFFF on timeout (held between reports)
//   dist_sensor  sensor index of the last result (held)
//   dist_timeout 1 = last result was a timeout (held)
//   dist_valid   one-cycle pulse when dist_* are updated
//   busy         1 whenever the scheduler is not idle
module ultrasonic_ping_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GUARD_CYCLES   = 500_000,
  parameter int DIST_DIV       = 2900,
  parameter int CNT_W          = 24
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic [15:0]            dist_data,
  output logic [2:0]             dist_sensor,
  output logic                   dist_timeout,
  output logic                   dist_valid,
  output logic                   busy
);

  localparam int SEL_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_TRIG      = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_MEASURE   = 3'd4,
    S_REPORT    = 3'd5,
    S_GUARD     = 3'd6
  } state_t;

  state_t                 r_state;
  logic [NUM_SENSORS-1:0] r_echo_meta;
  logic [NUM_SENSORS-1:0] r_echo_sync;
  logic [NUM_SENSORS-1:0] r_echo_prev;
  logic [SEL_W-1:0]       r_cur;
  logic [SEL_W-1:0]       r_rr;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_presc;
  logic [15:0]            r_cm;
  logic [NUM_SENSORS-1:0] r_trigger;
  logic [15:0]            r_dist_data;
  logic [2:0]             r_dist_sensor;
  logic                   r_dist_timeout;
  logic                   r_dist_valid;
  logic                   r_busy;

  logic [SEL_W-1:0]       w_next_sel;
  logic [NUM_SENSORS-1:0] w_sel_onehot;
  logic                   w_mask_any;
  logic                   w_echo_cur;
  logic                   w_echo_rise;

  // First set mask bit strictly after the round-robin pointer, wrapping; a
  // single enabled sensor therefore picks itself again.
  function automatic logic [SEL_W-1:0] f_next_sel(input logic [NUM_SENSORS-1:0] mask,
                                                  input logic [SEL_W-1:0]       rr);
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] idx;
    logic             found;
    sel   = rr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      idx = SEL_W'((int'(rr) + k) % NUM_SENSORS);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign w_next_sel  = f_next_sel(sensor_mask, r_rr);
  assign w_mask_any  = |sensor_mask;
  // Only the selected channel is ever looked at, so echo on others is ignored.
  assign w_echo_cur  = r_echo_sync[r_cur];
  assign w_echo_rise = r_echo_sync[r_cur] & ~r_echo_prev[r_cur];

  // One-hot trigger pattern for the sensor chosen in SELECT.
  always_comb begin
    w_sel_onehot             = '0;
    w_sel_onehot[w_next_sel] = 1'b1;
  end

  // Two-flop echo synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_echo_meta <= '0;
      r_echo_sync <= '0;
      r_echo_prev <= '0;
    end else begin
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;
      r_echo_prev <= r_echo_sync;
    end
  end

  // Ping scheduler FSM; results are registered on entry to REPORT so that
  // dist_valid is high exactly for the REPORT cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state        <= S_IDLE;
      r_cur          <= '0;
      r_rr           <= SEL_W'(NUM_SENSORS - 1);
      r_cnt          <= '0;
      r_presc        <= '0;
      r_cm           <= 16'd0;
      r_trigger      <= '0;
      r_dist_data    <= 16'd0;
      r_dist_sensor  <= 3'd0;
      r_dist_timeout <= 1'b0;
      r_dist_valid   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_dist_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && w_mask_any) begin
            r_state <= S_SELECT;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_SELECT: begin
          // Mask may have been cleared since the decision to come here.
          if (w_mask_any) begin
            r_cur     <= w_next_sel;
            r_trigger <= w_sel_onehot;
            r_cnt     <= '0;
            r_state   <= S_TRIG;
          end else begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end
        end
        S_TRIG: begin
          if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
            r_trigger <= '0;
            r_cnt     <= '0;
            r_state   <= S_WAIT_RISE;
          end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_RISE: begin
          if (w_echo_rise) begin
            r_cm    <= 16'd0;
            r_presc <= '0;
            r_cnt   <= '0;
            r_state <= S_MEASURE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_dist_valid   <= 1'b1;
            r_dist_sensor  <= 3'(r_cur);
            r_dist_data    <= 16'hFFFF;
            r_dist_timeout <= 1'b1;
            r_state        <= S_REPORT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_MEASURE: begin
          if (!w_echo_cur) begin
            r_dist_valid   <= 1'b1;
            r_dist_sensor  <= 3'(r_cur);
            r_dist_data    <= r_cm;
            r_dist_timeout <= 1'b0;
            r_state        <= S_REPORT;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_dist_valid   <= 1'b1;
            r_dist_sensor  <= 3'(r_cur);
            r_dist_data    <= 16'hFFFF;
            r_dist_timeout <= 1'b1;
            r_state        <= S_REPORT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Prescaler turns echo-high cycles into whole centimetres.
            if (r_presc == CNT_W'(DIST_DIV - 1)) begin
              r_presc <= '0;
              if (r_cm != 16'hFFFF) begin
                r_cm <= r_cm + 16'd1;
              end else begin
                r_cm <= r_cm;
              end
            end else begin
              r_presc <= r_presc + CNT_W'(1);
            end
          end
        end
        S_REPORT: begin
          r_rr    <= r_cur;
          r_cnt   <= '0;
          r_state <= S_GUARD;
        end
        S_GUARD: begin
          if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            r_cnt <= '0;
            if (enable && w_mask_any) begin
              r_state <= S_SELECT;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_trigger <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign trigger      = r_trigger;
  assign dist_data    = r_dist_data;
  assign dist_sensor  = r_dist_sensor;
  assign dist_timeout = r_dist_timeout;
  assign dist_valid   = r_dist_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Directed bench for ultrasonic_ping_scheduler with small timing parameters
// (TRIG=4, TIMEOUT=200, GUARD=20, DIST_DIV=10). A TB echo model answers each
// trigger; expected distances are echo-high cycles / 10 (edge cycle excluded).
module tb_ultrasonic_ping_scheduler;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        enable;
  logic [3:0]  sensor_mask;
  logic [3:0]  echo;
  logic [3:0]  trigger;
  logic [15:0] dist_data;
  logic [2:0]  dist_sensor;
  logic        dist_timeout;
  logic        dist_valid;
  logic        busy;

  int   checks      = 0;
  int   failures    = 0;
  int   onehot_viol = 0;
  int   dv_double   = 0;
  int   dv_count    = 0;
  logic prev_dv     = 1'b0;

  always #5 clk = ~clk;

  ultrasonic_ping_scheduler #(
    .NUM_SENSORS(4), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(200),
    .GUARD_CYCLES(20), .DIST_DIV(10), .CNT_W(24)
  ) dut (
    .clk(clk), .reset_l(reset_l), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo), .trigger(trigger), .dist_data(dist_data), .dist_sensor(dist_sensor),
    .dist_timeout(dist_timeout), .dist_valid(dist_valid), .busy(busy)
  );

  // Continuous monitor: one trigger at a time, dist_valid never two cycles running.
  always @(negedge clk) begin
    if (!$onehot0(trigger)) onehot_viol++;
    if (dist_valid && prev_dv) dv_double++;
    if (dist_valid) dv_count++;
    prev_dv = dist_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_l     = 1'b0;
    enable      = 1'b0;
    sensor_mask = 4'd0;
    echo        = 4'd0;
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
  endtask

  // Wait for the next trigger, check which sensor fired and that it lasts 4 cycles.
  task automatic wait_trig(input string tag, input int exp_idx);
    int n;
    int idx;
    int len;
    n = 0;
    while (trigger == 4'd0 && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_rise_seen"}, 32'(trigger != 4'd0), 32'd1);
    idx = -1;
    for (int i = 0; i < 4; i++) if (trigger[i]) idx = i;
    check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
    len = 0;
    while (trigger != 4'd0 && len < 100) begin @(negedge clk); len++; end
    check({tag, "_len"}, 32'(len), 32'd4);
  endtask

  // Echo pulse on sensor s: dly cycles after call, high for hi cycles.
  task automatic drive_echo(input int s, input int dly, input int hi, input int drop_at);
    repeat (dly) @(negedge clk);
    echo[s] = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      if (i == drop_at) enable = 1'b0;
    end
    echo[s] = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!dist_valid && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_valid_seen"}, 32'(dist_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input int s, input int d, input int to);
    check({tag, "_sensor"},  32'(dist_sensor),  32'(s));
    check({tag, "_data"},    32'(dist_data),    32'(d));
    check({tag, "_timeout"}, 32'(dist_timeout), 32'(to));
  endtask

  initial begin
    int n;
    int th;
    int dv0;

    // Reset state
    reset_l     = 1'b0;
    enable      = 1'b0;
    sensor_mask = 4'd0;
    echo        = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_trigger", 32'(trigger),      32'd0);
    check("rst_data",    32'(dist_data),    32'd0);
    check("rst_sensor",  32'(dist_sensor),  32'd0);
    check("rst_timeout", 32'(dist_timeout), 32'd0);
    check("rst_valid",   32'(dist_valid),   32'd0);
    check("rst_busy",    32'(busy),         32'd0);
    reset_l = 1'b1;
    @(negedge clk);

    // 1: mask 0101, 57-cycle echoes -> 5 cm, sensors 0,2,0
    sensor_mask = 4'b0101;
    enable      = 1'b1;
    wait_trig("t1a", 0);
    check("t1a_busy", 32'(busy), 32'd1);
    drive_echo(0, 3, 57, -1);
    wait_valid("t1a", n);
    check_result("t1a", 0, 5, 0);
    @(negedge clk);
    check("t1a_valid_pulse", 32'(dist_valid), 32'd0);
    check("t1a_data_held",   32'(dist_data),  32'd5);
    wait_trig("t1b", 2);
    drive_echo(2, 3, 57, -1);
    wait_valid("t1b", n);
    check_result("t1b", 2, 5, 0);
    wait_trig("t1c", 0);
    drive_echo(0, 3, 57, -1);
    wait_valid("t1c", n);
    check_result("t1c", 0, 5, 0);

    // 2: single sensor 1, no echo -> timeout 200 cycles after trigger falls
    do_reset();
    sensor_mask = 4'b0010;
    enable      = 1'b1;
    wait_trig("t2", 1);
    wait_valid("t2", n);
    check("t2_timeout_delay", 32'(n), 32'd200);
    check_result("t2", 1, 16'hFFFF, 1);
    echo[1] = 1'b1;
    @(negedge clk);
    check("t2_data_held", 32'(dist_data), 32'hFFFF);

    // 3: echo already high before trigger -> rise timeout, then a normal ping
    wait_trig("t3a", 1);
    wait_valid("t3a", n);
    check("t3a_timeout_delay", 32'(n), 32'd200);
    check_result("t3a", 1, 16'hFFFF, 1);
    echo[1] = 1'b0;
    wait_trig("t3b", 1);
    drive_echo(1, 3, 23, -1);
    wait_valid("t3b", n);
    check_result("t3b", 1, 2, 0);

    // 4: enable dropped during MEASURE -> result still posted, then idle
    do_reset();
    sensor_mask = 4'b0101;
    enable      = 1'b1;
    wait_trig("t4", 0);
    drive_echo(0, 3, 57, 10);
    wait_valid("t4", n);
    check_result("t4", 0, 5, 0);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("t4_busy_fall", 32'(n), 32'd21);
    th = 0;
    repeat (300) begin @(negedge clk); if (trigger != 4'd0) th++; end
    check("t4_no_trigger", 32'(th), 32'd0);
    check("t4_busy_idle",  32'(busy), 32'd0);

    // 5: reset pulsed in MEASURE -> outputs clear, no result, restart at sensor 0
    dv0    = dv_count;
    enable = 1'b1;
    wait_trig("t5a", 2);
    repeat (3) @(negedge clk);
    echo[2] = 1'b1;
    repeat (10) @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("t5_rst_trigger", 32'(trigger),    32'd0);
    check("t5_rst_busy",    32'(busy),       32'd0);
    check("t5_rst_valid",   32'(dist_valid), 32'd0);
    check("t5_rst_data",    32'(dist_data),  32'd0);
    repeat (3) @(negedge clk);
    echo    = 4'd0;
    reset_l = 1'b1;
    check("t5_no_result", 32'(dv_count - dv0), 32'd0);
    wait_trig("t5b", 0);
    drive_echo(0, 3, 57, -1);
    wait_valid("t5b", n);
    check_result("t5b", 0, 5, 0);

    // 6: echo activity on unselected channels is ignored
    wait_trig("t6", 2);
    repeat (2) @(negedge clk);
    echo[0] = 1'b1;
    echo[3] = 1'b1;
    repeat (5) @(negedge clk);
    echo[0] = 1'b0;
    echo[3] = 1'b0;
    repeat (2) @(negedge clk);
    echo[2] = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i == 10) echo[1] = 1'b1;
      if (i == 20) echo[1] = 1'b0;
      if (i == 25) echo[0] = 1'b1;
    end
    echo = 4'd0;
    wait_valid("t6", n);
    check_result("t6", 2, 3, 0);

    check("onehot0_trigger",  32'(onehot_viol), 32'd0);
    check("valid_single_cyc", 32'(dv_double),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
